// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: START P0..P3 STOP -> one write command; DUMP byte -> dump request.
// Optional macro UART_FRAME_CHECKSUM_EN adds a fifth XOR-checksum payload byte before STOP.
module uart_frame_parser #(
  parameter logic [7:0] START_BYTE = 8'hF5,
  parameter logic [7:0] STOP_BYTE  = 8'hFA,
  parameter logic [7:0] DUMP_BYTE  = 8'hF6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [9:0]  wr_addr,
  output logic [11:0] wr_data,
  output logic        dump_req,
  output logic        frame_err
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PAYLOAD     = 2'd1;
  localparam logic [1:0] EXPECT_STOP = 2'd2;
  localparam logic [1:0] PENDING     = 2'd3;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  p0_q, p0_d, p1_q, p1_d;
  logic [5:0]  p2_q, p2_d, p3_q, p3_d;
  logic        wr_valid_q, wr_valid_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic [11:0] wr_data_q, wr_data_d;
  logic        dump_q, dump_d;
  logic        err_q, err_d;

  logic is_start, is_stop, is_dump;
  logic payload_ok;
  logic idle_like;

  assign is_start = (rx_data == START_BYTE);
  assign is_stop  = (rx_data == STOP_BYTE);
  assign is_dump  = (rx_data == DUMP_BYTE);

  // A completing handshake frees the parser to treat a same-cycle byte as if idle.
  assign idle_like = (state_q == IDLE) || ((state_q == PENDING) && wr_ready);

`ifdef UART_FRAME_CHECKSUM_EN
  logic [5:0] chk_calc;
  assign chk_calc = {1'b0, p0_q} ^ {1'b0, p1_q} ^ p2_q ^ p3_q;
`endif

  always_comb begin
    payload_ok = 1'b0;
    case (cnt_q)
      3'd0, 3'd1: payload_ok = (rx_data[7:5] == 3'b000);
      3'd2, 3'd3: payload_ok = (rx_data[7:6] == 2'b00);
`ifdef UART_FRAME_CHECKSUM_EN
      3'd4:       payload_ok = (rx_data[7:6] == 2'b00) && (rx_data[5:0] == chk_calc);
`endif
      default:    payload_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    p3_d       = p3_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    dump_d     = 1'b0;
    err_d      = 1'b0;

    if (state_q == PENDING) begin
      if (wr_ready) begin
        wr_valid_d = 1'b0;
        state_d    = IDLE;
      end else if (rx_valid) begin
        err_d = 1'b1;
      end
    end

    if (rx_valid) begin
      if (idle_like) begin
        if (is_start) begin
          state_d = PAYLOAD;
          cnt_d   = 3'd0;
        end else if (is_dump) begin
          dump_d = 1'b1;
        end
      end else begin
        case (state_q)
          PAYLOAD: begin
            if (is_start) begin
              err_d   = 1'b1;
              state_d = PAYLOAD;
              cnt_d   = 3'd0;
            end else if (is_stop || is_dump || !payload_ok) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              case (cnt_q)
                3'd0:    p0_d = rx_data[4:0];
                3'd1:    p1_d = rx_data[4:0];
                3'd2:    p2_d = rx_data[5:0];
                3'd3:    p3_d = rx_data[5:0];
                default: ;
              endcase
              if (cnt_q == LAST_IDX) begin
                state_d = EXPECT_STOP;
              end else begin
                cnt_d = cnt_q + 3'd1;
              end
            end
          end
          EXPECT_STOP: begin
            if (is_stop) begin
              state_d    = PENDING;
              wr_valid_d = 1'b1;
              wr_addr_d  = {p0_q, p1_q};
              wr_data_d  = {p2_q, p3_q};
            end else if (is_start) begin
              err_d   = 1'b1;
              state_d = PAYLOAD;
              cnt_d   = 3'd0;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      p0_q       <= 5'd0;
      p1_q       <= 5'd0;
      p2_q       <= 6'd0;
      p3_q       <= 6'd0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 10'd0;
      wr_data_q  <= 12'd0;
      dump_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      p3_q       <= p3_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      dump_q     <= dump_d;
      err_q      <= err_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign dump_req  = dump_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed scenarios then random byte streams against a queue-based
// reference model; every output is compared on every cycle.
module tb_uart_frame_parser;

  localparam logic [7:0] START = 8'hF5;
  localparam logic [7:0] STOP  = 8'hFA;
  localparam logic [7:0] DUMP  = 8'hF6;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NPAY = 5;
`else
  localparam int NPAY = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_addr;
  logic [11:0] wr_data;
  logic        dump_req;
  logic        frame_err;

  int errors = 0;
  int checks = 0;

  uart_frame_parser dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dump_req  (dump_req),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Reference model: bytes collected since START, plus a pending command.
  bit          in_frame;
  logic [7:0]  pay[$];
  bit          pend;
  logic [9:0]  m_addr;
  logic [11:0] m_data;
  bit          m_err;
  bit          m_dump;

  function automatic bit pay_ok(input logic [7:0] b, input int idx, input logic [7:0] x);
    if (idx < 2) return b[7:5] == 3'b000;
    if (idx < 4) return b[7:6] == 2'b00;
    return (b[7:6] == 2'b00) && (b[5:0] == x[5:0]);
  endfunction

  task automatic model_reset();
    in_frame = 0; pay.delete(); pend = 0;
    m_addr = '0; m_data = '0; m_err = 0; m_dump = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic rdy);
    logic [7:0] x;
    m_err = 0; m_dump = 0;
    if (pend && rdy) pend = 0;
    if (!v) return;
    if (pend) begin
      m_err = 1;
    end else if (!in_frame) begin
      if (b == START) begin in_frame = 1; pay.delete(); end
      else if (b == DUMP) m_dump = 1;
    end else if (pay.size() < NPAY) begin
      x = (pay.size() >= 4) ? (pay[0] ^ pay[1] ^ pay[2] ^ pay[3]) : 8'h00;
      if (b == START) begin m_err = 1; pay.delete(); end
      else if (b == STOP || b == DUMP || !pay_ok(b, pay.size(), x)) begin
        m_err = 1; in_frame = 0;
      end else pay.push_back(b);
    end else begin
      if (b == START) begin m_err = 1; pay.delete(); end
      else if (b == STOP) begin
        in_frame = 0; pend = 1;
        m_addr = {pay[0][4:0], pay[1][4:0]};
        m_data = {pay[2][5:0], pay[3][5:0]};
      end else begin m_err = 1; in_frame = 0; end
    end
  endtask

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic v, input logic [7:0] b, input logic rdy);
    rst = r; rx_valid = v; rx_data = b; wr_ready = rdy;
    @(posedge clk);
    if (r) model_reset();
    else model_step(v, b, rdy);
    @(negedge clk);
    check("frame_err", {11'd0, frame_err}, {11'd0, m_err});
    check("dump_req", {11'd0, dump_req}, {11'd0, m_dump});
    check("wr_valid", {11'd0, wr_valid}, {11'd0, pend});
    check("wr_addr", {2'd0, wr_addr}, {2'd0, m_addr});
    check("wr_data", wr_data, m_data);
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    tick(1'b0, 1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic rdy);
    send(a, rdy); send(b, rdy); send(c, rdy); send(d, rdy);
`ifdef UART_FRAME_CHECKSUM_EN
    send(a ^ b ^ c ^ d, rdy);
`endif
    send(STOP, rdy);
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] p[4];
    int sel;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; wr_ready = 1'b0;
    model_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b1, START, 1'b1);

    // Basic frame, ready high.
    send(START, 1'b1);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
    idle(2, 1'b1);
    // Dump in idle, then dump mid-frame.
    send(DUMP, 1'b0); idle(1, 1'b0);
    send(START, 1'b0); send(8'h01, 1'b0); send(DUMP, 1'b0); idle(2, 1'b0);
    // Pending with no ready, stray byte, then handshake.
    send(START, 1'b0);
    send_frame(8'h1F, 8'h00, 8'h2A, 8'h15, 1'b0);
    idle(10, 1'b0);
    send(8'h11, 1'b0);
    idle(1, 1'b1); idle(1, 1'b0);
    // Restart on second START.
    send(START, 1'b1); send(8'h01, 1'b1); send(START, 1'b1);
    send_frame(8'h1F, 8'h02, 8'h3F, 8'h3F, 1'b1);
    idle(1, 1'b1);
    // Bad payload bits, then reset mid-frame.
    send(START, 1'b1); send(8'h20, 1'b1); send(8'h00, 1'b1); send(8'h00, 1'b1);
    send(8'h00, 1'b1); send(STOP, 1'b1);
    send(START, 1'b1); send(8'h01, 1'b1); send(8'h02, 1'b1);
    tick(1'b1, 1'b1, 8'h03, 1'b1);
    send(STOP, 1'b1); idle(1, 1'b1);
    // Byte arriving with the handshake opens a new frame.
    send(START, 1'b0); send_frame(8'h05, 8'h06, 8'h07, 8'h08, 1'b0);
    send(START, 1'b1); send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0);
    send(DUMP, 1'b1); idle(1, 1'b1);
`ifdef UART_FRAME_CHECKSUM_EN
    send(START, 1'b1); send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1);
    send(8'h04, 1'b1); send(8'h05, 1'b1); send(STOP, 1'b1); idle(1, 1'b1);
`endif

    // Random streams.
    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        fr.delete();
        p[0] = 8'($urandom_range(0, 31)); p[1] = 8'($urandom_range(0, 31));
        p[2] = 8'($urandom_range(0, 63)); p[3] = 8'($urandom_range(0, 63));
        fr.push_back(START);
        for (int k = 0; k < 4; k++) fr.push_back(p[k]);
        if (NPAY == 5) fr.push_back(p[0] ^ p[1] ^ p[2] ^ p[3]);
        fr.push_back(STOP);
        if ($urandom_range(0, 3) == 0) fr[$urandom_range(0, fr.size() - 1)] = 8'($urandom);
        foreach (fr[k]) begin
          send(fr[k], 1'($urandom_range(0, 2) == 0));
          idle($urandom_range(0, 2), 1'($urandom_range(0, 2) == 0));
        end
      end else if (sel == 5) send(DUMP, 1'($urandom_range(0, 1)));
      else if (sel == 6) send(8'($urandom), 1'($urandom_range(0, 1)));
      else if (sel == 7) tick(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      else idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
